// File: rtl/pdp1_terminal_pkg.sv
// Shared constants and types for the PDP-1 terminal glyph renderer.
// Contents: glyph cell geometry, pipeline latency, default screen and blink
// geometry, and the per-pixel sideband record carried down the pipeline.
package pdp1_terminal_pkg;

  localparam int unsigned GLYPH_W              = 16;
  localparam int unsigned GLYPH_H              = 16;
  localparam int unsigned PIPE_LATENCY         = 5;
  localparam int unsigned DEFAULT_COLS         = 64;
  localparam int unsigned DEFAULT_ROWS         = 32;
  localparam int unsigned DEFAULT_BLINK_FRAMES = 32;

  // Sideband that travels alongside the text/glyph memory lookups.
  typedef struct packed {
    logic       valid;
    logic       in_range;
    logic       cursor_hit;
    logic [3:0] glyph_col;
    logic [3:0] glyph_row;
  } pix_slot_t;

endpackage

// File: rtl/pdp1_terminal_cursor_blink.sv
// Cursor blink generator.
// Counts frame_start pulses modulo BLINK_FRAMES and toggles blink_phase each
// time the count wraps. blink_phase is 1 (cursor visible) out of reset.
// Ports:
//   clock       - rising-edge clock
//   reset       - synchronous, active-high
//   frame_start - one-cycle pulse per frame
//   blink_phase - current cursor visibility phase (registered)
module pdp1_terminal_cursor_blink
  import pdp1_terminal_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] count_q, count_d;
  logic          phase_q, phase_d;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (count_q == LAST) begin
        count_d = '0;
        phase_d = ~phase_q;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= 1'b1;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  // Registered phase: a pixel sampled alongside frame_start sees the old value.
  assign blink_phase = phase_q;

endmodule

// File: rtl/pdp1_terminal_glyph_renderer.sv
// PDP-1 terminal glyph renderer.
// Five-stage pixel pipeline: coordinate -> text RAM address (edge 1) ->
// glyph ROM address (edge 3) -> pixel (edge 5). Accepts one coordinate per
// cycle with no stalls. Cursor cell is inverted while the blink phase is on.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   pixel_x, pixel_y      - pixel coordinate; pixel_valid marks active display
//   frame_start           - one-cycle pulse per frame (drives cursor blink)
//   cursor_col/row/enable - cursor cell and display enable
//   text_address/data     - text buffer read port (1-cycle read latency)
//   charset_address/q     - glyph ROM read port (1-cycle read latency)
//   pixel_out(_valid)     - rendered pixel, pixel_valid delayed by 5 edges
module pdp1_terminal_glyph_renderer
  import pdp1_terminal_pkg::*;
#(
  parameter int unsigned COLS         = DEFAULT_COLS,
  parameter int unsigned ROWS         = DEFAULT_ROWS,
  parameter int unsigned BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        pixel_valid,
  input  logic        frame_start,
  input  logic [5:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        cursor_enable,
  output logic [10:0] text_address,
  input  logic [7:0]  text_data,
  output logic [11:0] charset_address,
  input  logic [15:0] charset_q,
  output logic        pixel_out,
  output logic        pixel_out_valid
);

  localparam int unsigned NSLOT = PIPE_LATENCY - 1;
  localparam logic [10:0] COLS_W = 11'(COLS);

  logic       blink_phase;
  logic [5:0] col;
  logic [4:0] line;
  logic       in_range;
  logic       cursor_hit;
  logic [10:0] text_address_d;
  pix_slot_t  new_slot;
  pix_slot_t  slot_q [NSLOT];
  pix_slot_t  last_slot;
  logic       pixel_out_d;

  pdp1_terminal_cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clock      (clock),
    .reset      (reset),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );

  assign col  = pixel_x[9:4];
  assign line = pixel_y[8:4];

  always_comb begin
    in_range   = (32'(pixel_x) < COLS * GLYPH_W) && (32'(pixel_y) < ROWS * GLYPH_H);
    cursor_hit = cursor_enable & blink_phase & (col == cursor_col) & (line == cursor_row);
    text_address_d = in_range ? (({6'b0, line} * COLS_W) + {5'b0, col}) : '0;

    new_slot            = '0;
    new_slot.valid      = pixel_valid;
    new_slot.in_range   = in_range;
    new_slot.cursor_hit = cursor_hit;
    new_slot.glyph_col  = pixel_x[3:0];
    new_slot.glyph_row  = pixel_y[3:0];
  end

  // Final stage: MSB of the glyph row is the leftmost pixel; invalid or
  // off-screen slots always render dark.
  always_comb begin
    last_slot   = slot_q[NSLOT-1];
    pixel_out_d = last_slot.valid & last_slot.in_range &
                  (charset_q[4'd15 - last_slot.glyph_col] ^ last_slot.cursor_hit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NSLOT); i++) begin
        slot_q[i] <= '0;
      end
      text_address    <= '0;
      charset_address <= '0;
      pixel_out       <= 1'b0;
      pixel_out_valid <= 1'b0;
    end else begin
      slot_q[0] <= new_slot;
      for (int i = 1; i < int'(NSLOT); i++) begin
        slot_q[i] <= slot_q[i-1];
      end
      text_address <= text_address_d;
      // slot_q[1] is the pixel whose text_data arrives this cycle.
      charset_address <= {text_data, slot_q[1].glyph_row};
      pixel_out       <= pixel_out_d;
      pixel_out_valid <= last_slot.valid;
    end
  end

endmodule

// File: doc/pdp1_terminal_glyph_renderer.md
PDP1_TERMINAL_GLYPH_RENDERER -- requirements
Module: pdp1_terminal_glyph_renderer

Interface
REQ-001 SHALL take parameter COLS, default 64, meaning text columns per line.
REQ-002 SHALL take parameter ROWS, default 32, meaning text lines per screen.
REQ-003 SHALL take parameter BLINK_FRAMES, default 32, meaning frames per cursor blink half-period.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port pixel_x, input, 11 bits: horizontal pixel coordinate.
REQ-007 SHALL have port pixel_y, input, 10 bits: vertical pixel coordinate.
REQ-008 SHALL have port pixel_valid, input, 1 bit: the coordinate is in the active display.
REQ-009 SHALL have port frame_start, input, 1 bit: one-cycle pulse per frame.
REQ-010 SHALL have port cursor_col, input, 6 bits, and cursor_row, input, 5 bits: cursor cell.
REQ-011 SHALL have port cursor_enable, input, 1 bit: cursor display enable.
REQ-012 SHALL have port text_address, output, 11 bits: text buffer read address.
REQ-013 SHALL have port text_data, input, 8 bits: FIO-DEC glyph code, valid one cycle after text_address.
REQ-014 SHALL have port charset_address, output, 12 bits: glyph ROM address.
REQ-015 SHALL have port charset_q, input, 16 bits: glyph row, valid one cycle after charset_address.
REQ-016 SHALL have port pixel_out, output, 1 bit, and pixel_out_valid, output, 1 bit: rendered pixel.

Function
REQ-017 SHALL map cell col = pixel_x[9:4], line = pixel_y[8:4], glyph row = pixel_y[3:0], glyph column = pixel_x[3:0].
REQ-018 SHALL register text_address = line*COLS + col at edge 1 after sampling.
REQ-019 SHALL register charset_address = {text_data[7:0], glyph row} at edge 3.
REQ-020 SHALL register pixel_out = charset_q[15 - glyph column] XOR cursor_hit at edge 5; MSB is leftmost pixel.
REQ-021 SHALL carry glyph column, glyph row, in-range flag, cursor_hit and valid through a pipeline so pixel_out_valid equals pixel_valid delayed by exactly 5 edges.
REQ-022 SHALL accept a new coordinate every cycle; no stalls, no backpressure.
REQ-023 SHALL force pixel_out = 0 when pixel_x >= COLS*16 or pixel_y >= ROWS*16, with pixel_out_valid still asserted; text_address then holds 0.
REQ-024 SHALL set cursor_hit = cursor_enable AND blink_phase AND col == cursor_col AND line == cursor_row, sampled at edge 1.
REQ-025 SHALL count frame_start pulses modulo BLINK_FRAMES and toggle blink_phase when the count wraps from BLINK_FRAMES-1 to 0.
REQ-026 SHALL apply a blink_phase toggle only from the cycle after the frame_start pulse; a pixel sampled in the same cycle as frame_start uses the old phase.
REQ-027 SHALL render pixel_out = 0 for any pipeline slot whose valid bit is 0.

Reset
REQ-028 SHALL, while reset is high, clear all pipeline valid bits, pixel_out, pixel_out_valid, text_address, charset_address and the blink counter to 0.
REQ-029 SHALL set blink_phase to 1 (cursor visible) on reset.
REQ-030 SHALL discard in-flight pixels on reset mid-frame; the first pixel_out_valid occurs 5 edges after the first pixel_valid sampled with reset low.

Structure
REQ-031 SHALL place GLYPH_W=16, GLYPH_H=16, PIPE_LATENCY=5 and default COLS, ROWS and BLINK_FRAMES in shared package pdp1_terminal_pkg.
REQ-032 SHALL implement the blink counter and phase in one sub-module, pdp1_terminal_cursor_blink.

Verification
REQ-033 SHALL test with the bench modelling the text RAM and glyph ROM at 1-cycle latency: code 0x21 at cell (2,1); x=37, y=21 -> text_address=66, charset_address=0x215, pixel_out=ROM[0x215] bit 10 five edges later.
REQ-034 SHALL test a continuous stream of 1024 valid pixels over one scanline: 1024 consecutive pixel_out_valid, none dropped or duplicated.
REQ-035 SHALL test out of range: x=1030 -> pixel_out=0, pixel_out_valid=1.
REQ-036 SHALL test the cursor: cursor (5,3) enabled, glyph row all zeros -> pixel_out=1 across that cell after reset; after 32 frame_start pulses -> 0; after 64 -> 1.
REQ-037 SHALL test reset with 3 pixels in flight: no pixel_out_valid for 5 edges after reset deasserts and pixel_valid is sampled, and blink_phase=1.
